// File: rtl/ctrl_fsm.sv
// Multicycle main control FSM: steps each instruction through fetch/decode/execute/
// memory/writeback and drives Moore-decoded datapath selects plus raw write enables.
module ctrl_fsm (
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] Op,
    input  logic [5:0] Funct,
    input  logic       FPUDone,
    output logic       IRWrite,
    output logic       AdrSrc,
    output logic       ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic       ALUOp,
    output logic [1:0] ResultSrc,
    output logic       NextPC,
    output logic       RegW,
    output logic       MemW,
    output logic       FPUW,
    output logic       Branch,
    output logic       FPUStart,
    output logic [3:0] State
);

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMRD    = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWR    = 4'd5,
        S_EXECUTER = 4'd6,
        S_EXECUTEI = 4'd7,
        S_ALUWB    = 4'd8,
        S_BRANCH   = 4'd9,
        S_FPUEX    = 4'd10,
        S_FPUWB    = 4'd11
    } state_t;

    typedef struct packed {
        logic       irwrite;
        logic       adrsrc;
        logic       alusrca;
        logic [1:0] alusrcb;
        logic       aluop;
        logic [1:0] resultsrc;
        logic       nextpc;
        logic       regw;
        logic       memw;
        logic       fpuw;
        logic       branch;
    } ctl_t;

    state_t r_state;
    state_t w_next;
    ctl_t   r_ctl;
    logic   r_fpustart;
    logic   w_unused_funct;

    // Only the immediate and load bits of Funct steer the sequence.
    assign w_unused_funct = &{1'b0, Funct[4:1]};

    function automatic state_t next_state(input state_t s, input logic [1:0] op,
                                          input logic imm, input logic load,
                                          input logic done);
        state_t n;
        n = S_FETCH;
        case (s)
            S_FETCH:    n = S_DECODE;
            S_DECODE: begin
                case (op)
                    2'b00:   n = imm ? S_EXECUTEI : S_EXECUTER;
                    2'b01:   n = S_MEMADR;
                    2'b10:   n = S_BRANCH;
                    default: n = S_FPUEX;
                endcase
            end
            S_MEMADR:   n = load ? S_MEMRD : S_MEMWR;
            S_MEMRD:    n = S_MEMWB;
            S_EXECUTER: n = S_ALUWB;
            S_EXECUTEI: n = S_ALUWB;
            S_FPUEX:    n = done ? S_FPUWB : S_FPUEX;
            default:    n = S_FETCH;
        endcase
        return n;
    endfunction

    function automatic ctl_t decode(input state_t s);
        ctl_t c;
        c = '0;
        case (s)
            S_FETCH: begin
                c.irwrite   = 1'b1;
                c.alusrca   = 1'b1;
                c.alusrcb   = 2'b10;
                c.resultsrc = 2'b10;
                c.nextpc    = 1'b1;
            end
            S_DECODE: begin
                c.alusrca   = 1'b1;
                c.alusrcb   = 2'b10;
                c.resultsrc = 2'b10;
            end
            S_MEMADR:   c.alusrcb = 2'b01;
            S_MEMRD:    c.adrsrc  = 1'b1;
            S_MEMWB: begin
                c.resultsrc = 2'b01;
                c.regw      = 1'b1;
            end
            S_MEMWR: begin
                c.adrsrc = 1'b1;
                c.memw   = 1'b1;
            end
            S_EXECUTER: c.aluop = 1'b1;
            S_EXECUTEI: begin
                c.alusrcb = 2'b01;
                c.aluop   = 1'b1;
            end
            S_ALUWB:    c.regw = 1'b1;
            S_BRANCH: begin
                c.alusrcb   = 2'b01;
                c.resultsrc = 2'b10;
                c.branch    = 1'b1;
            end
            S_FPUWB: begin
                c.resultsrc = 2'b11;
                c.fpuw      = 1'b1;
            end
            default:    c = '0;
        endcase
        return c;
    endfunction

    always_comb begin
        w_next = next_state(r_state, Op, Funct[5], Funct[0], FPUDone);
    end

    // Outputs are decoded from the next state so they are registered yet Moore-aligned.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= S_FETCH;
            r_ctl      <= decode(S_FETCH);
            r_fpustart <= 1'b0;
        end else begin
            r_state    <= w_next;
            r_ctl      <= decode(w_next);
            r_fpustart <= (r_state == S_DECODE) && (w_next == S_FPUEX);
        end
    end

    // Enables are masked by reset combinationally so an aborted instruction cannot write.
    assign IRWrite   = r_ctl.irwrite & ~reset;
    assign NextPC    = r_ctl.nextpc  & ~reset;
    assign RegW      = r_ctl.regw    & ~reset;
    assign MemW      = r_ctl.memw    & ~reset;
    assign FPUW      = r_ctl.fpuw    & ~reset;
    assign Branch    = r_ctl.branch  & ~reset;
    assign FPUStart  = r_fpustart    & ~reset;
    assign AdrSrc    = r_ctl.adrsrc;
    assign ALUSrcA   = r_ctl.alusrca;
    assign ALUSrcB   = r_ctl.alusrcb;
    assign ALUOp     = r_ctl.aluop;
    assign ResultSrc = r_ctl.resultsrc;
    assign State     = r_state;

endmodule

// File: tb/tb_ctrl_fsm.sv
// Scoreboard bench for ctrl_fsm: a driver expands each instruction into its expected
// per-cycle state/output sequence; a negedge monitor pops and compares every cycle.
module tb_ctrl_fsm;

    logic       clk;
    logic       reset;
    logic [1:0] Op;
    logic [5:0] Funct;
    logic       FPUDone;
    logic       IRWrite, AdrSrc, ALUSrcA, ALUOp, NextPC, RegW, MemW, FPUW, Branch, FPUStart;
    logic [1:0] ALUSrcB, ResultSrc;
    logic [3:0] State;

    ctrl_fsm dut (
        .clk(clk), .reset(reset), .Op(Op), .Funct(Funct), .FPUDone(FPUDone),
        .IRWrite(IRWrite), .AdrSrc(AdrSrc), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
        .ALUOp(ALUOp), .ResultSrc(ResultSrc), .NextPC(NextPC), .RegW(RegW),
        .MemW(MemW), .FPUW(FPUW), .Branch(Branch), .FPUStart(FPUStart), .State(State)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] st;
        logic [6:0] en;
        logic [6:0] sel;
        bit         chk_sel;
    } exp_t;

    exp_t q[$];
    int   n_chk  = 0;
    int   n_fail = 0;
    bit   mon_en = 1'b0;

    // Enables packed as {IRWrite, NextPC, RegW, MemW, FPUW, Branch, FPUStart}.
    function automatic logic [6:0] exp_en(input int st, input bit first_fpu);
        case (st)
            0:       return 7'b1100000;
            4, 8:    return 7'b0010000;
            5:       return 7'b0001000;
            9:       return 7'b0000010;
            10:      return first_fpu ? 7'b0000001 : 7'b0000000;
            11:      return 7'b0000100;
            default: return 7'b0000000;
        endcase
    endfunction

    // Selects packed as {AdrSrc, ALUSrcA, ALUSrcB[1:0], ALUOp, ResultSrc[1:0]}.
    function automatic logic [6:0] exp_sel(input int st);
        case (st)
            0, 1:    return 7'b0_1_10_0_10;
            2:       return 7'b0_0_01_0_00;
            3, 5:    return 7'b1_0_00_0_00;
            4:       return 7'b0_0_00_0_01;
            6:       return 7'b0_0_00_1_00;
            7:       return 7'b0_0_01_1_00;
            9:       return 7'b0_0_01_0_10;
            11:      return 7'b0_0_00_0_11;
            default: return 7'b0_0_00_0_00;
        endcase
    endfunction

    task automatic run_instr(input logic [1:0] op, input logic [5:0] funct,
                             input int n_wait, input int rst_at);
        int   seq[$];
        exp_t e;
        bit   first;
        seq.push_back(0);
        seq.push_back(1);
        case (op)
            2'b00: begin
                seq.push_back(funct[5] ? 7 : 6);
                seq.push_back(8);
            end
            2'b01: begin
                seq.push_back(2);
                if (funct[0]) begin
                    seq.push_back(3);
                    seq.push_back(4);
                end else begin
                    seq.push_back(5);
                end
            end
            2'b10: seq.push_back(9);
            default: begin
                for (int k = 0; k <= n_wait; k++) seq.push_back(10);
                seq.push_back(11);
            end
        endcase
        for (int i = 0; i < seq.size(); i++) begin
            Op    = op;
            Funct = funct;
            if (seq[i] == 10) FPUDone = (i == seq.size() - 2);
            else              FPUDone = 1'($urandom_range(0, 1));
            reset = (i == rst_at);
            first = (seq[i] == 10) && (i > 0) && (seq[i-1] == 1);
            e.st = 4'(seq[i]);
            if (reset) begin
                e.en      = 7'b0;
                e.sel     = 7'b0;
                e.chk_sel = 1'b0;
            end else begin
                e.en      = exp_en(seq[i], first);
                e.sel     = exp_sel(seq[i]);
                e.chk_sel = 1'b1;
            end
            q.push_back(e);
            @(posedge clk);
            #1;
            if (reset) begin
                reset = 1'b0;
                break;
            end
        end
    endtask

    always @(negedge clk) begin
        exp_t m;
        if (mon_en) begin
            if (q.size() == 0) begin
                n_chk++;
                n_fail++;
                $display("FAIL underflow at %0t: DUT output with no expected entry", $time);
            end else begin
                m = q.pop_front();
                n_chk++;
                if (State !== m.st) begin
                    n_fail++;
                    $display("FAIL state at %0t: got %0d expected %0d", $time, State, m.st);
                end
                n_chk++;
                if ({IRWrite, NextPC, RegW, MemW, FPUW, Branch, FPUStart} !== m.en) begin
                    n_fail++;
                    $display("FAIL enables at %0t (state %0d): got %b expected %b", $time,
                             m.st, {IRWrite, NextPC, RegW, MemW, FPUW, Branch, FPUStart}, m.en);
                end
                if (m.chk_sel) begin
                    n_chk++;
                    if ({AdrSrc, ALUSrcA, ALUSrcB, ALUOp, ResultSrc} !== m.sel) begin
                        n_fail++;
                        $display("FAIL selects at %0t (state %0d): got %b expected %b", $time,
                                 m.st, {AdrSrc, ALUSrcA, ALUSrcB, ALUOp, ResultSrc}, m.sel);
                    end
                end
            end
        end
    end

    initial begin
        exp_t e;
        logic [1:0] op;
        logic [5:0] fn;
        int nw, ra;
        reset   = 1'b1;
        Op      = 2'b00;
        Funct   = 6'b0;
        FPUDone = 1'b0;
        @(posedge clk);
        #1;
        mon_en = 1'b1;
        // Remaining two reset cycles: State already FETCH, enables held low.
        for (int i = 0; i < 2; i++) begin
            FPUDone   = 1'($urandom_range(0, 1));
            e.st      = 4'd0;
            e.en      = 7'b0;
            e.sel     = 7'b0;
            e.chk_sel = 1'b0;
            q.push_back(e);
            @(posedge clk);
            #1;
        end
        reset = 1'b0;

        run_instr(2'b00, 6'b101000, 0, -1);
        run_instr(2'b00, 6'b001000, 0, -1);
        run_instr(2'b01, 6'b000001, 0, -1);
        run_instr(2'b01, 6'b000000, 0, -1);
        run_instr(2'b10, 6'b110110, 0, -1);
        run_instr(2'b11, 6'b000000, 3, -1);
        run_instr(2'b11, 6'b000000, 0, -1);
        run_instr(2'b11, 6'b000000, 5, 4);
        run_instr(2'b01, 6'b100001, 0, 3);
        run_instr(2'b10, 6'b000000, 0, -1);

        for (int n = 0; n < 300; n++) begin
            op = 2'($urandom);
            fn = 6'($urandom);
            nw = $urandom_range(0, 6);
            ra = ($urandom_range(0, 19) == 0) ? $urandom_range(0, 5) : -1;
            run_instr(op, fn, nw, ra);
        end

        mon_en = 1'b0;
        n_chk++;
        if (q.size() != 0) begin
            n_fail++;
            $display("FAIL drain: %0d expected entries left, required 0", q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
